spi_tx_fifo: RTL and testbench
==============================

SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64: command word width, with format {pad,dest,origin,index,addr,data}.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, a power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port push, input, 1 bit: write request from the MMU/bus side.
REQ-007 SHALL have port data_in, input, WIDTH bits: word to write.
REQ-008 SHALL have port pop, input, 1 bit: read request from the SPI engine.
REQ-009 SHALL have port D_out, output, WIDTH bits: head-of-queue word to the SPI engine.
REQ-010 SHALL have port pndgn, output, 1 bit: FIFO not empty; a word is pending.
REQ-011 SHALL have port full_tx, output, 1 bit: FIFO full.
REQ-012 SHALL have port afull, output, 1 bit: count >= AF_LEVEL.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: occupancy.
REQ-014 SHALL have port ovf, output, 1 bit: sticky overflow.
REQ-015 SHALL have port udf, output, 1 bit: sticky underflow.
REQ-016 SHALL have port clr_err, input, 1 bit: synchronous clear of ovf and udf.

Function
REQ-017 SHALL store words in circular order using read/write pointers of log2(DEPTH) bits; each pointer wraps from DEPTH-1 to 0.
REQ-018 SHALL accept a push only when full_tx=0, or when full_tx=1 and an accepted pop occurs in the same cycle.
REQ-019 SHALL accept a pop only when pndgn=1.
REQ-020 SHALL leave count unchanged on simultaneous accepted push and pop, and write and read in the same cycle.
REQ-021 SHALL ignore pop when empty, even if push is high in the same cycle; the pushed word is accepted and pndgn rises on the next cycle.
REQ-022 SHALL drive pndgn = (count!=0), full_tx = (count==DEPTH) and afull = (count>=AF_LEVEL), all decoded from registered count, with no combinational path from push or pop.
REQ-023 SHALL set ovf on push while full without a concurrent pop; the word is discarded and the contents are unchanged.
REQ-024 SHALL set udf on pop while empty.
REQ-025 SHALL hold ovf and udf until clr_err=1; clr_err has priority over a same-cycle set.
REQ-026 SHALL not change D_out when a push is rejected.

Reset
REQ-027 SHALL, on reset_n=0 (asynchronous), clear count, pointers, ovf and udf to 0, so that pndgn=0, full_tx=0 and afull=0.
REQ-028 SHALL reset D_out to all zeros; storage contents are not reset.
REQ-029 SHALL abandon any operation in progress when reset is asserted mid-operation; no partial write survives.
REQ-030 SHALL accept a push on the first rising edge after reset_n deasserts.

Configuration
REQ-031 SHALL, with SPI_TX_FIFO_FWFT_EN defined, operate first-word-fall-through: D_out shows the head entry whenever pndgn=1, valid in the same cycle pndgn rises, and advances to the next entry the cycle after an accepted pop.
REQ-032 SHALL, without SPI_TX_FIFO_FWFT_EN, register D_out: it loads the popped entry one cycle after an accepted pop and holds its value otherwise, giving 1-cycle read latency.

Verification
REQ-033 SHALL pass: after reset, push {1'b0,2'b01,2'b00,3'h7,25'h555555,32'hAAAAAAAA} -> next cycle pndgn=1, count=1; with FWFT, D_out equals that word.
REQ-034 SHALL pass: push 8 words 0..7 with DEPTH=8 -> full_tx=1, afull asserted at count=6; a ninth push sets ovf=1 and count stays 8; popping all 8 returns 0..7 in order.
REQ-035 SHALL pass: full FIFO, push and pop in the same cycle -> count stays 8, ovf stays 0, and the new word is read last.
REQ-036 SHALL pass: pop while empty -> udf=1, count=0; clr_err for 1 cycle -> udf=0.
REQ-037 SHALL pass: 20 push/pop pairs with DEPTH=8 -> pointers wrap with no data loss, and data read equals data written.
REQ-038 SHALL pass: reset_n low with count=5 -> pndgn=0, count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: transmit command queue between the MMU/bus side and the SPI engine.
//
// Optional feature macro: SPI_TX_FIFO_FWFT_EN
//   defined   -> first-word-fall-through: D_out shows the head entry while pndgn=1.
//   undefined -> D_out is registered and loads the popped entry one cycle after
//                an accepted pop (1-cycle read latency).
//
// Parameters
//   WIDTH    : command word width {pad,dest,origin,index,addr,data}
//   DEPTH    : number of entries (power of two, >= 2)
//   AF_LEVEL : almost-full threshold on count
//
// Ports
//   CLK      in   clock; all state changes on the rising edge
//   reset_n  in   asynchronous active-low reset
//   push     in   write request
//   data_in  in   word to write
//   pop      in   read request
//   clr_err  in   synchronous clear of ovf/udf (wins over a same-cycle set)
//   D_out    out  head-of-queue / popped word
//   pndgn    out  FIFO not empty
//   full_tx  out  FIFO full
//   afull    out  count >= AF_LEVEL
//   count    out  occupancy
//   ovf      out  sticky overflow (push while full with no concurrent pop)
//   udf      out  sticky underflow (pop while empty)

module spi_tx_fifo #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         D_out,
    output logic                     pndgn,
    output logic                     full_tx,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Thresholds sized to the count register so the compares are width-exact.
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, udf_q;

    logic          pop_acc, push_acc;

    // Status flags decode only the registered count, so push/pop never reach
    // them combinationally.
    assign pndgn   = (cnt_q != '0);
    assign full_tx = (cnt_q == FULL_CNT);
    assign afull   = (cnt_q >= AF_CNT);
    assign count   = cnt_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

    // A pop is honoured only with data pending. A push is honoured when there is
    // room, or when full but the head is leaving in the same cycle.
    assign pop_acc  = pop & pndgn;
    assign push_acc = push & (~full_tx | pop_acc);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Sticky error flags; clr_err overrides a set in the same cycle.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clr_err) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (push && !push_acc) ovf_q <= 1'b1;
            if (pop && !pndgn)     udf_q <= 1'b1;
        end
    end

    // Storage is not reset. The reset_n term keeps a push that coincides with
    // reset from landing in the array.
    always_ff @(posedge CLK) begin
        if (push_acc && reset_n) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef SPI_TX_FIFO_FWFT_EN
    // Head entry is visible as soon as pndgn rises; zero while empty so the
    // output matches its reset value.
    assign D_out = pndgn ? mem[rd_ptr_q] : '0;
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else if (pop_acc) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign D_out = dout_q;
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo (WIDTH=64, DEPTH=8, AF_LEVEL=6).
// Works for both the registered-output and the FWFT build.

module tb_spi_tx_fifo;

    logic        CLK;
    logic        reset_n;
    logic        push;
    logic [63:0] data_in;
    logic        pop;
    logic        clr_err;
    logic [63:0] D_out;
    logic        pndgn;
    logic        full_tx;
    logic        afull;
    logic [3:0]  count;
    logic        ovf;
    logic        udf;

    int checks;
    int failures;

    spi_tx_fifo #(
        .WIDTH    (64),
        .DEPTH    (8),
        .AF_LEVEL (6)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (push),
        .data_in (data_in),
        .pop     (pop),
        .clr_err (clr_err),
        .D_out   (D_out),
        .pndgn   (pndgn),
        .full_tx (full_tx),
        .afull   (afull),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [63:0] data;
        logic [3:0]  cnt;
        logic        pnd;
        logic        full;
        logic        af;
        logic        ovf;
        logic        udf;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic ps, logic pp, logic cl, logic [63:0] d, logic [3:0] c,
                                logic pn, logic fu, logic a, logic o, logic u);
        vec_t v;
        v.push = ps; v.pop = pp; v.clr = cl; v.data = d; v.cnt = c;
        v.pnd = pn; v.full = fu; v.af = a; v.ovf = o; v.udf = u;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
    endtask

    task automatic push_word(input logic [63:0] d);
        push = 1'b1; data_in = d;
        step();
        idle_inputs();
    endtask

    // Pop one word and compare it: before the edge for FWFT, after it otherwise.
    task automatic pop_expect(input string name, input logic [63:0] exp);
`ifdef SPI_TX_FIFO_FWFT_EN
        chk(name, D_out, exp);
        pop = 1'b1;
        step();
        idle_inputs();
`else
        pop = 1'b1;
        step();
        idle_inputs();
        chk(name, D_out, exp);
`endif
    endtask

    task automatic pushpop_expect(input string name, input logic [63:0] d,
                                  input logic [63:0] exp);
`ifdef SPI_TX_FIFO_FWFT_EN
        chk(name, D_out, exp);
        push = 1'b1; pop = 1'b1; data_in = d;
        step();
        idle_inputs();
`else
        push = 1'b1; pop = 1'b1; data_in = d;
        step();
        idle_inputs();
        chk(name, D_out, exp);
`endif
    endtask

    logic [63:0] w33;
    logic [63:0] exp_hold;

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();

        // Starting from empty: underflow, clear priority, push+pop on empty,
        // then fill to full, overflow and clear priority on ovf.
        tbl[0]  = mk(0, 1, 0, 64'h0,    4'd0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 64'h0,    4'd0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 64'h0,    4'd0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 64'h50,   4'd1, 1, 0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 64'h0,    4'd0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 1, 64'h0,    4'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tbl[6+i] = mk(1, 0, 0, 64'(i), 4'(i + 1), 1, (i == 7), (i >= 5), 0, 0);
        end
        tbl[14] = mk(1, 0, 0, 64'hDEAD, 4'd8, 1, 1, 1, 1, 0);
        tbl[15] = mk(1, 0, 1, 64'hBEEF, 4'd8, 1, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 64'h0,    4'd8, 1, 1, 1, 0, 0);

        // Reset state
        reset_n = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pndgn", 64'(pndgn), 64'd0);
        chk("rst_full",  64'(full_tx), 64'd0);
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_ovf",   64'(ovf), 64'd0);
        chk("rst_udf",   64'(udf), 64'd0);
        chk("rst_dout",  D_out, 64'd0);
        @(negedge CLK);
        reset_n = 1'b1;

        // Example command word; the leading pad bit falls outside 64 bits.
        w33 = {2'b01, 2'b00, 3'h7, 25'h555555, 32'hAAAAAAAA};
        push_word(w33);
        chk("first_pndgn", 64'(pndgn), 64'd1);
        chk("first_count", 64'(count), 64'd1);
`ifdef SPI_TX_FIFO_FWFT_EN
        chk("first_fwft_dout", D_out, w33);
`endif
        pop_expect("first_pop", w33);
        chk("first_empty", 64'(count), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            push = tbl[i].push; pop = tbl[i].pop; clr_err = tbl[i].clr; data_in = tbl[i].data;
            step();
            idle_inputs();
            chk($sformatf("v%0d_count", i), 64'(count),   64'(tbl[i].cnt));
            chk($sformatf("v%0d_pndgn", i), 64'(pndgn),   64'(tbl[i].pnd));
            chk($sformatf("v%0d_full",  i), 64'(full_tx), 64'(tbl[i].full));
            chk($sformatf("v%0d_afull", i), 64'(afull),   64'(tbl[i].af));
            chk($sformatf("v%0d_ovf",   i), 64'(ovf),     64'(tbl[i].ovf));
            chk($sformatf("v%0d_udf",   i), 64'(udf),     64'(tbl[i].udf));
        end

        // Rejected pushes leave D_out alone: FWFT shows head 0, registered
        // output still holds the 0x50 popped in vector 4.
`ifdef SPI_TX_FIFO_FWFT_EN
        exp_hold = 64'h0;
`else
        exp_hold = 64'h50;
`endif
        chk("ovf_dout_hold", D_out, exp_hold);

        // Full FIFO, push and pop together: count holds, no overflow,
        // new word comes out last.
        pushpop_expect("full_pp_head", 64'd100, 64'd0);
        chk("full_pp_count", 64'(count), 64'd8);
        chk("full_pp_ovf",   64'(ovf), 64'd0);
        for (int i = 1; i < 8; i++) begin
            pop_expect($sformatf("drain_%0d", i), 64'(i));
        end
        pop_expect("drain_new", 64'd100);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_pndgn", 64'(pndgn), 64'd0);

        // 20 push/pop pairs walk both pointers around the ring 2.5 times.
        for (int i = 0; i < 20; i++) begin
            push_word(64'h1000 + 64'(i * 3));
            pop_expect($sformatf("wrap_%0d", i), 64'h1000 + 64'(i * 3));
        end
        chk("wrap_count", 64'(count), 64'd0);

        // Asynchronous reset with 5 entries: flags clear without a clock edge.
        for (int i = 0; i < 5; i++) push_word(64'h2000 + 64'(i));
        chk("pre_rst_count", 64'(count), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_pndgn", 64'(pndgn), 64'd0);
        chk("async_dout",  D_out, 64'd0);
        @(negedge CLK);
        reset_n = 1'b1;

        // First edge after reset accepts a push; pointers restarted at 0.
        push_word(64'h3333);
        chk("post_rst_count", 64'(count), 64'd1);
        pop_expect("post_rst_pop", 64'h3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
